// File: rtl/button_pio_pkg.sv
// rtl/button_pio_pkg.sv - shared constants and types for the debounced button PIO
// Contents: register word addresses, EDGE_CFG fall-enable field offset,
//           channel-count ceiling and the per-channel debounce state type.
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_EDGE_CFG = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int FALL_EN_LSB = 16;
  localparam int MAX_WIDTH   = 16;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_fsm_e;

endpackage

// File: rtl/button_debounce_chan.sv
// rtl/button_debounce_chan.sv - one input channel: 2-flop synchroniser, debounce FSM, edge pulses
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   raw asynchronous pin
//   level    out  debounced level
//   rise     out  1-cycle pulse, valid in the cycle level goes 0->1
//   fall     out  1-cycle pulse, valid in the cycle level goes 1->0
module button_debounce_chan
  import button_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  db_fsm_e       state;

  // The counter holds the number of mismatching cycles already seen, so the
  // DEBOUNCE_CYCLES-th consecutive mismatch is the one that commits the level.
  // With DEBOUNCE_CYCLES=1 that happens straight from STABLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
      level <= IDLE_LEVEL;
      cnt   <= '0;
      state <= DB_STABLE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      case (state)
        DB_STABLE: begin
          if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
              level <= sync2;
              rise  <= sync2;
              fall  <= ~sync2;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + CW'(1);
              state <= DB_PENDING;
            end
          end
        end
        DB_PENDING: begin
          if (sync2 == level) begin
            cnt   <= '0;
            state <= DB_STABLE;
          end else if (cnt == CNT_LAST) begin
            level <= sync2;
            rise  <= sync2;
            fall  <= ~sync2;
            cnt   <= '0;
            state <= DB_STABLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/button_pio_db.sv
// rtl/button_pio_db.sv - Avalon-MM input PIO with debounce, edge capture and level IRQ
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register word address (DATA, EDGE_CFG, IRQ_MASK, EDGE_CAP)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  registered read data, 1-cycle latency, follows address
//   in_port     in   raw button/switch pins
//   irq         out  registered level interrupt, |(EDGE_CAP & IRQ_MASK)
module button_pio_db
  import button_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] db_level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .level  (db_level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    cap_set = (rise & rise_en) | (fall & fall_en);
    cap_clr = '0;
    if (wr_en && address == ADDR_EDGE_CAP) begin
      cap_clr = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0] = db_level;
      ADDR_EDGE_CFG: begin
        rd_next[WIDTH-1:0]             = rise_en;
        rd_next[FALL_EN_LSB +: WIDTH]  = fall_en;
      end
      ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_next[WIDTH-1:0] = edge_cap;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en  <= '0;
      fall_en  <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_EDGE_CFG: begin
            rise_en <= writedata[WIDTH-1:0];
            fall_en <= writedata[FALL_EN_LSB +: WIDTH];
          end
          ADDR_IRQ_MASK: irq_mask <= writedata[WIDTH-1:0];
          default: ;
        endcase
      end
      // A new edge overrides a same-cycle W1C on that bit so no event is lost.
      edge_cap <= (edge_cap & ~cap_clr) | cap_set;
      irq      <= |(edge_cap & irq_mask);
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_button_pio_db.sv
// tb/tb_button_pio_db.sv - scoreboard bench for button_pio_db (WIDTH=4, DEBOUNCE_CYCLES=8)
module tb_button_pio_db;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CFG  = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CAP  = 2'd3;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
    logic        chk_irq;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  logic  rd_req = 1'b0;
  logic  rd_vld = 1'b0;
  int    n_cmp  = 0;
  int    n_bad  = 0;

  always #5 clk = ~clk;

  button_pio_db #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(8),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // readdata and irq registered on the request edge are compared half a cycle later.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: readdata=0x%08h with no expected entry", readdata);
      end else begin
        exp_t  it;
        string nm;
        it = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (readdata !== it.rd) begin
          n_bad++;
          $display("FAIL %s: readdata=0x%08h expected 0x%08h", nm, readdata, it.rd);
        end
        if (it.chk_irq) begin
          n_cmp++;
          if (irq !== it.irq) begin
            n_bad++;
            $display("FAIL %s_irq: irq=%0b expected %0b", nm, irq, it.irq);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic ci,
                    input logic ei, input string nm);
    exp_t it;
    it.rd      = e;
    it.irq     = ei;
    it.chk_irq = ci;
    exp_q.push_back(it);
    name_q.push_back(nm);
    address    = a;
    chipselect = 1'b1;
    rd_req     = 1'b1;
    @(posedge clk);
    #1;
    rd_req     = 1'b0;
    chipselect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    idle(3);
    reset_n = 1'b1;

    // Reset state and quiet inputs
    rd(A_DATA, 32'hF, 1'b1, 1'b0, "rst_data");
    rd(A_CFG,  32'h0, 1'b1, 1'b0, "rst_cfg");
    rd(A_MASK, 32'h0, 1'b1, 1'b0, "rst_mask");
    for (int i = 0; i < 50; i++) rd(A_CAP, 32'h0, 1'b1, 1'b0, "rst_cap");

    // Register access, unused bits and read-only DATA
    wr(A_CFG, 32'h000F_0000);
    wr(A_MASK, 32'hFFFF_FFFF);
    rd(A_MASK, 32'hF, 1'b1, 1'b0, "mask_unused_bits");
    wr(A_MASK, 32'h1);
    wr(A_DATA, 32'h0);
    rd(A_DATA, 32'hF, 1'b0, 1'b0, "data_ro");
    rd(A_CFG, 32'h000F_0000, 1'b0, 1'b0, "cfg_readback");

    // ch0 press: db level commits on edge 10, bus shows it on edge 11,
    // capture lands on edge 11 and irq on edge 12
    in_port[0] = 1'b0;
    idle(9);
    rd(A_DATA, 32'hF, 1'b1, 1'b0, "ch0_edge10");
    rd(A_DATA, 32'hE, 1'b1, 1'b0, "ch0_edge11");
    rd(A_CAP,  32'h1, 1'b1, 1'b1, "ch0_cap");

    // 5-cycle glitch on ch1 is rejected
    in_port[1] = 1'b0;
    idle(5);
    in_port[1] = 1'b1;
    idle(15);
    rd(A_DATA, 32'hE, 1'b0, 1'b0, "glitch_data");
    rd(A_CAP,  32'h1, 1'b1, 1'b1, "glitch_cap");

    // W1C and set-wins-over-clear
    in_port[1] = 1'b0;
    idle(15);
    rd(A_CAP, 32'h3, 1'b1, 1'b1, "cap_two");
    wr(A_CAP, 32'h1);
    rd(A_CAP, 32'h2, 1'b1, 1'b0, "w1c_bit0");
    in_port[1] = 1'b1;
    idle(15);
    rd(A_CAP, 32'h2, 1'b0, 1'b0, "rise_disabled");
    in_port[1] = 1'b0;
    idle(10);
    wr(A_CAP, 32'h2);
    rd(A_CAP, 32'h2, 1'b0, 1'b0, "set_wins");
    wr(A_CAP, 32'h2);
    rd(A_CAP, 32'h0, 1'b1, 1'b0, "w1c_bit1");
    rd(A_DATA, 32'hC, 1'b0, 1'b0, "data_ch01_low");

    // Rising-only config with masked irq
    wr(A_CFG, 32'h0000_000F);
    wr(A_MASK, 32'h0);
    rd(A_CFG, 32'hF, 1'b0, 1'b0, "cfg_rise_only");
    in_port[2] = 1'b0;
    idle(15);
    rd(A_DATA, 32'h8, 1'b0, 1'b0, "ch2_pressed");
    rd(A_CAP,  32'h0, 1'b1, 1'b0, "press_not_captured");
    in_port[2] = 1'b1;
    idle(15);
    rd(A_DATA, 32'hC, 1'b0, 1'b0, "ch2_released");
    rd(A_CAP,  32'h4, 1'b1, 1'b0, "release_captured_masked");
    wr(A_MASK, 32'h4);
    rd(A_MASK, 32'h4, 1'b1, 1'b1, "irq_after_unmask");

    // Reset in the middle of a ch3 debounce count
    in_port[3] = 1'b0;
    idle(8);
    reset_n = 1'b0;
    rd(A_DATA, 32'h0, 1'b1, 1'b0, "in_reset");
    reset_n = 1'b1;
    rd(A_CFG,  32'h0, 1'b1, 1'b0, "post_rst_cfg");
    rd(A_MASK, 32'h0, 1'b1, 1'b0, "post_rst_mask");
    rd(A_CAP,  32'h0, 1'b1, 1'b0, "post_rst_cap");
    idle(6);
    rd(A_DATA, 32'hF, 1'b0, 1'b0, "post_rst_edge10");
    rd(A_DATA, 32'h4, 1'b0, 1'b0, "post_rst_edge11");
    rd(A_CAP,  32'h0, 1'b1, 1'b0, "post_rst_no_capture");

    idle(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
